// File: rtl/b_resolve_queue_if.sv
// ---------------------------------------------------------------------------
// b_resolve_queue_if
// Bundles the prediction input channel, the resolution input, the correction
// back channel and the status outputs of b_resolve_queue.
//   slave  : the queue side (b_resolve_queue)
//   master : the surrounding pipeline / testbench side
// Signal names carry the queue's i_/o_ direction prefixes, so they read the
// same from either modport.
// ---------------------------------------------------------------------------
interface b_resolve_queue_if;
    // prediction channel
    logic        i_predValid;
    logic        o_predReady;
    logic [31:0] i_predPc_32;
    logic        i_predTaken;
    logic [31:0] i_predTarget_32;
    // execute-stage resolution of the oldest branch
    logic        i_resValid;
    logic        i_resTaken;
    logic [31:0] i_resTarget_32;
    // correction token back channel
    logic        o_drive_back;
    logic [32:0] o_data_back_33;
    logic        i_free_back;
    // status
    logic        o_flush;
    logic [3:0]  o_count_4;
    logic        o_underflow;

    modport slave (
        input  i_predValid, i_predPc_32, i_predTaken, i_predTarget_32,
        input  i_resValid, i_resTaken, i_resTarget_32,
        input  i_free_back,
        output o_predReady, o_drive_back, o_data_back_33,
        output o_flush, o_count_4, o_underflow
    );

    modport master (
        output i_predValid, i_predPc_32, i_predTaken, i_predTarget_32,
        output i_resValid, i_resTaken, i_resTarget_32,
        output i_free_back,
        input  o_predReady, o_drive_back, o_data_back_33,
        input  o_flush, o_count_4, o_underflow
    );
endinterface

// File: rtl/b_resolve_queue.sv
// ---------------------------------------------------------------------------
// b_resolve_queue
// Holds predicted branches in program order and checks the oldest one against
// each execute-stage resolution. A correct resolution pops the head; a
// mispredict clears the whole queue (every entry, plus any push in the same
// cycle, is younger than the bad branch) and raises a 33-bit correction token
// {1'b1, correctPc} on the back channel until the consumer takes it.
//
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - b_resolve_queue_if.slave:
//          i_predValid/o_predReady/i_predPc_32/i_predTaken/i_predTarget_32
//          i_resValid/i_resTaken/i_resTarget_32
//          o_drive_back/o_data_back_33/i_free_back
//          o_flush/o_count_4/o_underflow
// ---------------------------------------------------------------------------
module b_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    b_resolve_queue_if.slave   bus
);

    typedef enum logic {S_RUN = 1'b0, S_REPORT = 1'b1} state_t;

    state_t r_state, w_state_nxt;

    // entry storage {pc, taken, target}
    logic [31:0]      r_pc   [DEPTH];
    logic             r_taken[DEPTH];
    logic [31:0]      r_tgt  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_drive, r_flush, r_underflow;
    logic [32:0]      r_data;

    logic             w_ready, w_push, w_res, w_mispred, w_pop, w_under, w_ack;
    logic [31:0]      w_head_pc, w_head_tgt, w_cpc;
    logic             w_head_taken;

    // ---------------- resolution decode ----------------
    assign w_head_pc    = r_pc[r_rd_ptr];
    assign w_head_taken = r_taken[r_rd_ptr];
    assign w_head_tgt   = r_tgt[r_rd_ptr];

    assign w_res     = (r_state == S_RUN) && bus.i_resValid && (r_count != '0);
    assign w_under   = (r_state == S_RUN) && bus.i_resValid && (r_count == '0);
    // a target mismatch only matters when both sides say taken
    assign w_mispred = w_res && ((w_head_taken != bus.i_resTaken) ||
                       (w_head_taken && bus.i_resTaken && (w_head_tgt != bus.i_resTarget_32)));
    assign w_pop     = w_res && !w_mispred;
    assign w_cpc     = bus.i_resTaken ? bus.i_resTarget_32 : (w_head_pc + 32'd4);
    assign w_push    = bus.i_predValid && w_ready;
    assign w_ack     = r_drive && bus.i_free_back;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_mispred) w_state_nxt = S_REPORT;
            S_REPORT: if (w_ack)     w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // count never exceeds DEPTH (a power of two), so its MSB alone means full.
    // Ready deliberately ignores a same-cycle pop.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_RUN:    w_ready = !r_count[PTR_W];
            default:  w_ready = 1'b0;
        endcase
    end

    // ---------------- entry storage ----------------
    always_ff @(posedge clk) begin
        if (w_push && !w_mispred) begin
            r_pc[r_wr_ptr]    <= bus.i_predPc_32;
            r_taken[r_wr_ptr] <= bus.i_predTaken;
            r_tgt[r_wr_ptr]   <= bus.i_predTarget_32;
        end
    end

    // ---------------- pointers / occupancy ----------------
    always_ff @(posedge clk) begin
        if (rst || w_mispred) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- token and pulses ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drive     <= 1'b0;
            r_data      <= '0;
            r_flush     <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_flush     <= w_mispred;
            r_underflow <= w_under;
            if (w_mispred) begin
                r_drive <= 1'b1;
                r_data  <= {1'b1, w_cpc};   // bit 32 set keeps it distinct from the all-zero front token
            end else if (w_ack) begin
                r_drive <= 1'b0;
                r_data  <= '0;
            end
        end
    end

    assign bus.o_predReady    = w_ready;
    assign bus.o_drive_back   = r_drive;
    assign bus.o_data_back_33 = r_data;
    assign bus.o_flush        = r_flush;
    assign bus.o_underflow    = r_underflow;
    assign bus.o_count_4      = 4'(r_count);

endmodule
